// File: rtl/pps_timebase_pkg.sv
// Shared constants for the PPS-disciplined timebase: FSM state encodings and
// the saturating error-counter helper.
package pps_timebase_pkg;

  typedef logic [1:0] state_t;

  localparam state_t HUNT = 2'd0;
  localparam state_t LOCK = 2'd1;
  localparam state_t HOLD = 2'd2;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] cnt);
    return (cnt == ERR_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/pps_timebase_if.sv
// Bus bundle for pps_timebase. Optional timestamp latch signals exist only
// when PPS_TIMEBASE_LATCH_EN is defined.
interface pps_timebase_if
  import pps_timebase_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SEC_W = 32
);
  // sec_load is a single-cycle strobe qualifying sec_load_val; ts_req is a
  // single-cycle strobe answered by ts_valid exactly one cycle later.
  // There is no backpressure on either path.
  logic             pps_in;
  logic             sec_load;
  logic [SEC_W-1:0] sec_load_val;
  logic [CNT_W-1:0] sub_cnt;
  logic [SEC_W-1:0] sec_cnt;
  logic             pps_pulse;
  logic             pps_valid;
  logic             pps_miss;
  logic [ERR_W-1:0] err_cnt;
  state_t           state;
`ifdef PPS_TIMEBASE_LATCH_EN
  logic             ts_req;
  logic [SEC_W-1:0] ts_sec;
  logic [CNT_W-1:0] ts_sub;
  logic             ts_valid;

  modport master (
    output pps_in, sec_load, sec_load_val, ts_req,
    input  sub_cnt, sec_cnt, pps_pulse, pps_valid, pps_miss, err_cnt, state,
           ts_sec, ts_sub, ts_valid
  );
  modport slave (
    input  pps_in, sec_load, sec_load_val, ts_req,
    output sub_cnt, sec_cnt, pps_pulse, pps_valid, pps_miss, err_cnt, state,
           ts_sec, ts_sub, ts_valid
  );
`else
  modport master (
    output pps_in, sec_load, sec_load_val,
    input  sub_cnt, sec_cnt, pps_pulse, pps_valid, pps_miss, err_cnt, state
  );
  modport slave (
    input  pps_in, sec_load, sec_load_val,
    output sub_cnt, sec_cnt, pps_pulse, pps_valid, pps_miss, err_cnt, state
  );
`endif
endinterface

// File: rtl/pps_edge_sync.sv
// Two-flop synchroniser for the asynchronous PPS input followed by a
// rising-edge detector; edge_pulse is high for one clk cycle per rise.
module pps_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic edge_pulse
);

  logic meta;
  logic sync;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta   <= d;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  assign edge_pulse = sync & ~sync_q;

endmodule

// File: rtl/pps_timebase.sv
// PPS-disciplined {seconds, sub-second cycle} timebase with window checking
// and holdover. Define PPS_TIMEBASE_LATCH_EN to add the timestamp latch port.
module pps_timebase
  import pps_timebase_pkg::*;
#(
  parameter int CLK_FREQ = 300000000,
  parameter int PPS_TOL  = 1000,
  parameter int CNT_W    = 32,
  parameter int SEC_W    = 32
) (
  input logic           clk,
  input logic           rst,
  pps_timebase_if.slave bus
);

  localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(CLK_FREQ - 1 - PPS_TOL);
  localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(CLK_FREQ - 1 + PPS_TOL);
  localparam logic [CNT_W-1:0] WRAP   = CNT_W'(CLK_FREQ - 1);
  localparam logic [CNT_W-1:0] TOL    = CNT_W'(PPS_TOL);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] sub;
  logic [CNT_W-1:0] sub_n;
  logic [SEC_W-1:0] sec;
  logic [SEC_W-1:0] load_val;
  logic [SEC_W-1:0] load_next;
  logic             armed;
  logic             load_hit;
  logic             pulse;
  logic             bump;
  logic             err_inc;
  logic [ERR_W-1:0] err;
  logic             pps_edge;

  pps_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .d          (bus.pps_in),
    .edge_pulse (pps_edge)
  );

  // bump marks a second boundary: SEC_CNT advance (or load) plus PPS_PULSE.
  always_comb begin
    state_n = state;
    sub_n   = sub + ONE;
    bump    = 1'b0;
    err_inc = 1'b0;
    case (state)
      HUNT: begin
        sub_n = '0;
        if (pps_edge) begin
          bump    = 1'b1;
          state_n = LOCK;
        end
      end
      LOCK: begin
        if (pps_edge) begin
          if (sub >= WIN_LO) begin
            sub_n = '0;
            bump  = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end else if (sub == WIN_HI) begin
          // Missing edge: the late boundary is PPS_TOL cycles old already.
          sub_n   = TOL;
          bump    = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (sub == WRAP) begin
          sub_n = '0;
          bump  = 1'b1;
        end
        if (pps_edge) begin
          if (sub <= TOL) begin
            // Edge just after a virtual boundary: realign without a new second.
            sub_n   = '0;
            bump    = 1'b0;
            state_n = LOCK;
          end else if (sub >= WIN_LO) begin
            sub_n   = '0;
            bump    = 1'b1;
            state_n = LOCK;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      default: begin
        sub_n   = '0;
        state_n = HUNT;
      end
    endcase
  end

  // A load in the boundary cycle itself applies to that boundary.
  assign load_hit  = armed | bus.sec_load;
  assign load_next = bus.sec_load ? bus.sec_load_val : load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      sub      <= '0;
      sec      <= '0;
      armed    <= 1'b0;
      load_val <= '0;
      pulse    <= 1'b0;
      err      <= '0;
    end else begin
      state <= state_n;
      sub   <= sub_n;
      pulse <= bump;
      armed <= bump ? 1'b0 : load_hit;
      if (bus.sec_load) load_val <= bus.sec_load_val;
      if (bump) sec <= load_hit ? load_next : sec + SEC_W'(1);
      if (err_inc) err <= err_sat_inc(err);
    end
  end

  assign bus.sub_cnt   = sub;
  assign bus.sec_cnt   = sec;
  assign bus.pps_pulse = pulse;
  assign bus.pps_valid = (state == LOCK);
  assign bus.pps_miss  = (state == HOLD);
  assign bus.err_cnt   = err;
  assign bus.state     = state;

`ifdef PPS_TIMEBASE_LATCH_EN
  logic [SEC_W-1:0] ts_sec;
  logic [CNT_W-1:0] ts_sub;
  logic             ts_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_sec   <= '0;
      ts_sub   <= '0;
      ts_valid <= 1'b0;
    end else begin
      ts_valid <= bus.ts_req;
      if (bus.ts_req) begin
        ts_sec <= sec;
        ts_sub <= sub;
      end
    end
  end

  assign bus.ts_sec   = ts_sec;
  assign bus.ts_sub   = ts_sub;
  assign bus.ts_valid = ts_valid;
`endif

endmodule

// File: tb/tb_pps_timebase.sv
// Directed bench for pps_timebase with a scaled-down second (1000 cycles,
// +/-4 cycle window); edge records are table-driven.
module tb_pps_timebase;
  import pps_timebase_pkg::*;

  localparam int CLK_FREQ = 1000;
  localparam int PPS_TOL  = 4;
  localparam int CNT_W    = 16;
  localparam int SEC_W    = 32;

  typedef struct {
    int          edge_sub;   // SUB_CNT seen in the cycle pps_edge is high
    int          load_mode;  // 0 none, 1 load before edge, 2 load in boundary cycle
    logic [31:0] load_val;
    logic [31:0] exp_sec;
    logic [7:0]  exp_err;
    logic [1:0]  exp_state;
    logic        exp_pulse;
    int          exp_sub;    // SUB_CNT one cycle after the edge cycle
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vec [0:12];

  pps_timebase_if #(.CNT_W(CNT_W), .SEC_W(SEC_W)) bus ();

  pps_timebase #(
    .CLK_FREQ (CLK_FREQ),
    .PPS_TOL  (PPS_TOL),
    .CNT_W    (CNT_W),
    .SEC_W    (SEC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_sub(input int target);
    int n;
    n = 0;
    while (bus.sub_cnt != target && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL wait_sub: timeout waiting for sub_cnt %0d, got %0d", target, bus.sub_cnt);
    end
  endtask

  task automatic apply_edge(input vec_t v);
    wait_sub(v.edge_sub - 2);
    bus.pps_in = 1'b1;
    if (v.load_mode == 1) begin
      bus.sec_load     = 1'b1;
      bus.sec_load_val = v.load_val;
    end
    step();
    bus.sec_load = 1'b0;
    step();
    chk("sub_at_edge", 32'(bus.sub_cnt), v.edge_sub);
    if (v.load_mode == 2) begin
      bus.sec_load     = 1'b1;
      bus.sec_load_val = v.load_val;
    end
    step();
    bus.sec_load = 1'b0;
    chk("sub_after", 32'(bus.sub_cnt), v.exp_sub);
    chk("sec_cnt", bus.sec_cnt, v.exp_sec);
    chk("err_cnt", 32'(bus.err_cnt), 32'(v.exp_err));
    chk("state", 32'(bus.state), 32'(v.exp_state));
    chk("pps_pulse", 32'(bus.pps_pulse), 32'(v.exp_pulse));
    bus.pps_in = 1'b0;
  endtask

  initial begin
    int n;
    //           edge  ld  load_val      exp_sec       err   state pulse sub
    vec[0]  = '{ 999,  0,  32'h0,        32'd2,        8'd0, LOCK, 1'b1, 0   };
    vec[1]  = '{ 999,  0,  32'h0,        32'd3,        8'd0, LOCK, 1'b1, 0   };
    vec[2]  = '{ 995,  0,  32'h0,        32'd4,        8'd0, LOCK, 1'b1, 0   };
    vec[3]  = '{ 1003, 0,  32'h0,        32'd5,        8'd0, LOCK, 1'b1, 0   };
    vec[4]  = '{ 989,  0,  32'h0,        32'd5,        8'd1, LOCK, 1'b0, 990 };
    vec[5]  = '{ 999,  0,  32'h0,        32'd6,        8'd1, LOCK, 1'b1, 0   };
    vec[6]  = '{ 999,  1,  32'h100,      32'h100,      8'd1, LOCK, 1'b1, 0   };
    vec[7]  = '{ 999,  2,  32'h200,      32'h200,      8'd1, LOCK, 1'b1, 0   };
    vec[8]  = '{ 999,  0,  32'h0,        32'h201,      8'd1, LOCK, 1'b1, 0   };
    vec[9]  = '{ 999,  0,  32'h0,        32'h5678,     8'd1, LOCK, 1'b1, 0   };
    vec[10] = '{ 999,  0,  32'h0,        32'h5679,     8'd1, LOCK, 1'b1, 0   };
    vec[11] = '{ 500,  0,  32'h0,        32'h567B,     8'd2, HOLD, 1'b0, 501 };
    vec[12] = '{ 2,    0,  32'h0,        32'h567C,     8'd2, LOCK, 1'b0, 0   };

    bus.pps_in       = 1'b0;
    bus.sec_load     = 1'b0;
    bus.sec_load_val = '0;
`ifdef PPS_TIMEBASE_LATCH_EN
    bus.ts_req       = 1'b0;
`endif

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_sub", 32'(bus.sub_cnt), 0);
    chk("rst_sec", bus.sec_cnt, 0);
    chk("rst_pulse", 32'(bus.pps_pulse), 0);
    chk("rst_valid", 32'(bus.pps_valid), 0);
    chk("rst_miss", 32'(bus.pps_miss), 0);
    chk("rst_err", 32'(bus.err_cnt), 0);
    chk("rst_state", 32'(bus.state), 32'(HUNT));

    // First edge from HUNT: three cycles of sync/detect latency, then lock
    bus.pps_in = 1'b1;
    step();
    step();
    chk("hunt_sub_held", 32'(bus.sub_cnt), 0);
    step();
    chk("lock_sec", bus.sec_cnt, 1);
    chk("lock_sub", 32'(bus.sub_cnt), 0);
    chk("lock_pulse", 32'(bus.pps_pulse), 1);
    chk("lock_valid", 32'(bus.pps_valid), 1);
    bus.pps_in = 1'b0;
    step();
    chk("pulse_one_cycle", 32'(bus.pps_pulse), 0);
    chk("sub_counting", 32'(bus.sub_cnt), 1);

    // Locked periods, window edges, early edge, load arming
    for (int i = 0; i <= 8; i++) apply_edge(vec[i]);

    // Two loads before one boundary: latest wins, then normal increment
    wait_sub(500);
    bus.sec_load = 1'b1; bus.sec_load_val = 32'h1234;
    step();
    bus.sec_load = 1'b0;
    step();
    bus.sec_load = 1'b1; bus.sec_load_val = 32'h5678;
    step();
    bus.sec_load = 1'b0;
    apply_edge(vec[9]);
    apply_edge(vec[10]);

    // PPS stops: holdover entry at the window's upper limit
    wait_sub(1003);
    chk("pre_hold_valid", 32'(bus.pps_valid), 1);
    step();
    chk("hold_sub", 32'(bus.sub_cnt), 4);
    chk("hold_sec", bus.sec_cnt, 32'h567A);
    chk("hold_pulse", 32'(bus.pps_pulse), 1);
    chk("hold_miss", 32'(bus.pps_miss), 1);
    chk("hold_valid", 32'(bus.pps_valid), 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.pps_pulse && n < 2000);
    chk("hold_wrap_cycles", n, 996);
    chk("hold_wrap_sec", bus.sec_cnt, 32'h567B);
    chk("hold_wrap_sub", 32'(bus.sub_cnt), 0);

    // Holdover: stray edge mid-second, then a slightly late edge realigns
    apply_edge(vec[11]);
    apply_edge(vec[12]);
    chk("relock_valid", 32'(bus.pps_valid), 1);
    chk("relock_miss", 32'(bus.pps_miss), 0);

    // Reset mid-second with a load armed
    wait_sub(100);
    bus.sec_load = 1'b1; bus.sec_load_val = 32'h9999;
    step();
    bus.sec_load = 1'b0;
    wait_sub(500);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_sub", 32'(bus.sub_cnt), 0);
    chk("mid_rst_sec", bus.sec_cnt, 0);
    chk("mid_rst_err", 32'(bus.err_cnt), 0);
    chk("mid_rst_valid", 32'(bus.pps_valid), 0);
    chk("mid_rst_miss", 32'(bus.pps_miss), 0);
    chk("mid_rst_state", 32'(bus.state), 32'(HUNT));
    repeat (5) step();
    chk("post_rst_sub_held", 32'(bus.sub_cnt), 0);
    bus.pps_in = 1'b1;
    repeat (3) step();
    chk("post_rst_sec", bus.sec_cnt, 1);
    chk("post_rst_valid", 32'(bus.pps_valid), 1);
    chk("post_rst_pulse", 32'(bus.pps_pulse), 1);
    bus.pps_in = 1'b0;

`ifdef PPS_TIMEBASE_LATCH_EN
    // Timestamp latch: capture in the cycle after the relock boundary
    bus.ts_req = 1'b1;
    step();
    bus.ts_req = 1'b0;
    chk("ts_valid", 32'(bus.ts_valid), 1);
    chk("ts_sec", bus.ts_sec, 1);
    chk("ts_sub", 32'(bus.ts_sub), 0);
    step();
    chk("ts_valid_drop", 32'(bus.ts_valid), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
